fsmc_page_buffer: RTL and testbench
===================================

# fsmc_page_buffer

Page buffer between the FSMC NAND-style front end (CLE/ALE/NWE/NRE/NCE decoder driving NWAIT and the 16-bit bidirectional bus) and the FPGA fabric. It holds one page of host-written words, streams them to fabric after the program-confirm command, and fetches a page from fabric for host reads on the read-confirm command. Its busy output drives NWAIT and the status word returned for command 0x70.

## Interface
- DATA_W, 16, word width; equals `FSMC_WIDTH`.
- PAGE_WORDS, 16, words per page; power of two, at least 2.
- ROW_W, 16, width of the page (row) address.
---
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- fe_prog_start  in  1  1-cycle pulse: command 0x80 plus row address complete.
- fe_prog_commit  in  1  1-cycle pulse: command 0x10 decoded.
- fe_read_start  in  1  1-cycle pulse: command 0x30 decoded.
- fe_row  in  ROW_W  row address; valid with either start pulse.
- fe_wr  in  1  1-cycle pulse per host data-word write.
- fe_wdata  in  DATA_W  write word; valid with fe_wr.
- fe_rd  in  1  1-cycle pulse per host word read; fired on NRE rising.
- fe_rdata  out  DATA_W  current head word of the read page.
- fe_busy  out  1  1 while draining or fetching; drives NWAIT low.
- fe_status  out  DATA_W  NAND status word.
- out_valid / out_ready / out_data[DATA_W] / out_last / out_row[ROW_W]: program stream to fabric, valid/ready.
- in_req  out  1  page-fetch request level; held until the first in_valid&in_ready.
- in_row  out  ROW_W  row being fetched.
- in_valid / in_ready / in_data[DATA_W]: fetch stream from fabric, valid/ready.

## Operation
- States: IDLE, FILL, DRAIN, FETCH, SERVE.
- IDLE: fe_prog_start latches fe_row, clears the word count and fail bit, and moves to FILL. fe_read_start latches the row, clears fail, and moves to FETCH. All other strobes are ignored.
- FILL: each fe_wr stores fe_wdata at index wcnt and increments wcnt.
  - An fe_wr with wcnt==PAGE_WORDS is dropped and sets fail.
  - fe_prog_commit moves to DRAIN.
  - fe_prog_start restarts FILL: count cleared, new row.
- DRAIN: emits words 0..N-1, where N is defined under Configuration.
  - out_row is the latched row.
  - out_last is asserted on word N-1.
  - After the last out_valid&out_ready the block returns to IDLE.
  - Commit with wcnt==0 and padding disabled goes straight to IDLE and sets fail.
- FETCH: in_req is asserted. Exactly PAGE_WORDS in_valid&in_ready beats are written at indices 0..PAGE_WORDS-1. in_ready is 1 only in FETCH. After the last beat the block moves to SERVE with the read pointer at 0.
- SERVE: fe_rdata equals mem[rptr]. Each fe_rd increments rptr.
  - fe_rd with rptr==PAGE_WORDS returns 16'hFFFF and sets fail.
  - fe_prog_start or fe_read_start exits SERVE as they would from IDLE.
- fe_busy = 1 in DRAIN and FETCH, else 0.
- fe_status = {zeros, bit6 = ~fe_busy, bit5 = ~fe_busy, bit0 = fail}. Example: idle and no fail gives 16'h0060.
- Strobes arriving while busy are ignored, except that fe_rd in FETCH sets fail.

## Timing
- Reset values:
  - state IDLE; fe_busy 0; fe_status 16'h0060; fe_rdata 0.
  - out_valid 0, out_last 0, out_data 0, out_row 0.
  - in_req 0, in_ready 0, in_row 0.
  - Reset mid-operation abandons the page; buffer contents are undefined, pointers are cleared.
- fe_busy rises on the clock edge after fe_prog_commit or fe_read_start.
- out_valid is first asserted 1 cycle after entering DRAIN.
- out_data and out_valid are registered. With out_ready held high the block sustains 1 word/cycle. out_data is stable while out_valid=1 and out_ready=0.
- fe_rdata is registered. It updates 1 cycle after fe_rd and is valid in the first SERVE cycle. fe_rd pulses must be at least 2 cycles apart.
- fail is sticky until the next start pulse.

## Configuration
- FSMC_PAGE_PAD_EN:
  - Defined: N = PAGE_WORDS always. Unwritten indices are emitted as 16'hFFFF (erased-flash value). A commit with 0 words drains a full erased page and does not set fail.
  - Undefined: N = wcnt, and only written words are emitted.

## Test plan
- Program 16 words 0..15 to row 0, commit, out_ready=1 -> 16 beats 0..15 on consecutive cycles, out_last on 15, fe_busy high throughout, fe_status 16'h0060 afterwards.
- Program 3 words, commit -> with FSMC_PAGE_PAD_EN: 16 beats ending in 13×16'hFFFF; without: 3 beats, out_last on the 3rd.
- Program 17 words -> 17th dropped, fe_status 16'h0061 after drain; next fe_prog_start clears it to 16'h0060.
- Read row 5 (fe_read_start with fe_row=5): in_row=5, in_req high; fabric supplies 16'hA000+i with random in_valid gaps -> fe_busy falls after beat 15; 16 fe_rd pulses return 16'hA000..16'hA00F; a 17th returns 16'hFFFF and fail sets.
- DRAIN with out_ready toggling every cycle -> no word lost or duplicated; out_data stable while stalled.
- reset driven low in the middle of DRAIN -> all outputs at reset values asynchronously; the next program page drains correctly.

Source files
------------

// File: rtl/fsmc_page_buffer.sv
// -----------------------------------------------------------------------------
// fsmc_page_buffer
//   One-page buffer between the FSMC NAND-style front end and the FPGA fabric.
//   Host writes fill the page; program-confirm streams it out to fabric.
//   Read-confirm fetches a page from fabric, which the host then reads word by
//   word. fe_busy drives NWAIT; fe_status is the word returned for command 0x70.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   fe_prog_start       0x80 + row address complete (pulse)
//   fe_prog_commit      0x10 decoded (pulse)
//   fe_read_start       0x30 decoded (pulse)
//   fe_row              row address, valid with either start pulse
//   fe_wr / fe_wdata    host word write
//   fe_rd / fe_rdata    host word read (pulse on NRE rising) / head word
//   fe_busy, fe_status  NWAIT source, NAND status word
//   out_*               program stream to fabric (valid/ready)
//   in_req, in_row      page-fetch request level and row
//   in_valid/in_ready/in_data  fetch stream from fabric (valid/ready)
//
// Build option
//   FSMC_PAGE_PAD_EN    when defined, every drain emits a full page and
//                       unwritten words read as 16'hFFFF (erased flash).
// -----------------------------------------------------------------------------
module fsmc_page_buffer #(
    parameter int DATA_W     = 16,
    parameter int PAGE_WORDS = 16,
    parameter int ROW_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fe_prog_start,
    input  logic              fe_prog_commit,
    input  logic              fe_read_start,
    input  logic [ROW_W-1:0]  fe_row,
    input  logic              fe_wr,
    input  logic [DATA_W-1:0] fe_wdata,
    input  logic              fe_rd,
    output logic [DATA_W-1:0] fe_rdata,
    output logic              fe_busy,
    output logic [DATA_W-1:0] fe_status,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [ROW_W-1:0]  out_row,
    output logic              in_req,
    output logic [ROW_W-1:0]  in_row,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data
);
    localparam int AW = $clog2(PAGE_WORDS);
    localparam int CW = AW + 1;   // counts reach PAGE_WORDS

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_DRAIN, S_FETCH, S_SERVE} state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic [CW-1:0]     dptr_q, dptr_d;
    logic [AW-1:0]     fcnt_q, fcnt_d;
    logic [CW-1:0]     rptr_q, rptr_d;
    logic              fail_q, fail_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] fe_rdata_q, fe_rdata_d;
    logic              fe_busy_q, fe_busy_d;
    logic [DATA_W-1:0] fe_status_q, fe_status_d;
    logic              in_req_q, in_req_d;
    logic              in_ready_q, in_ready_d;

    // Page storage has no reset: contents are don't-care after reset.
    logic [DATA_W-1:0] mem [PAGE_WORDS];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [CW-1:0]     n_words;
    logic [DATA_W-1:0] drain_word;
    logic [CW-1:0]     rptr_nxt;
    logic [DATA_W-1:0] rdata_nxt;

`ifdef FSMC_PAGE_PAD_EN
    assign n_words    = CW'(PAGE_WORDS);
    // Writes are sequential from 0, so anything at or past wcnt is unwritten.
    assign drain_word = (dptr_q < wcnt_q) ? mem[dptr_q[AW-1:0]] : '1;
`else
    assign n_words    = wcnt_q;
    assign drain_word = mem[dptr_q[AW-1:0]];
`endif

    // Head word after the next host read; past the page end reads erased.
    assign rptr_nxt  = rptr_q + CW'(1);
    assign rdata_nxt = (rptr_nxt < CW'(PAGE_WORDS)) ? mem[rptr_nxt[AW-1:0]] : '1;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        wcnt_d      = wcnt_q;
        dptr_d      = dptr_q;
        fcnt_d      = fcnt_q;
        rptr_d      = rptr_q;
        fail_d      = fail_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        fe_rdata_d  = fe_rdata_q;
        in_req_d    = in_req_q;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;

        case (state_q)
            S_IDLE, S_SERVE: begin
                if (fe_prog_start) begin
                    state_d = S_FILL;
                    row_d   = fe_row;
                    wcnt_d  = '0;
                    fail_d  = 1'b0;
                end else if (fe_read_start) begin
                    state_d  = S_FETCH;
                    row_d    = fe_row;
                    fcnt_d   = '0;
                    fail_d   = 1'b0;
                    in_req_d = 1'b1;
                end else if (state_q == S_SERVE && fe_rd) begin
                    if (rptr_q == CW'(PAGE_WORDS)) begin
                        fail_d = 1'b1;
                    end else begin
                        rptr_d     = rptr_nxt;
                        fe_rdata_d = rdata_nxt;
                    end
                end
            end
            S_FILL: begin
                if (fe_prog_start) begin
                    row_d  = fe_row;
                    wcnt_d = '0;
                    fail_d = 1'b0;
                end else if (fe_prog_commit) begin
                    if (n_words == '0) begin
                        state_d = S_IDLE;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                        dptr_d  = '0;
                    end
                end else if (fe_wr) begin
                    if (wcnt_q == CW'(PAGE_WORDS)) begin
                        fail_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = wcnt_q[AW-1:0];
                        mem_wdata = fe_wdata;
                        wcnt_d    = wcnt_q + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = S_IDLE;
                end else if (!out_valid_q || out_ready) begin
                    // Output register empty or being consumed: load next word.
                    out_valid_d = 1'b1;
                    out_data_d  = drain_word;
                    out_last_d  = (dptr_q == n_words - CW'(1));
                    dptr_d      = dptr_q + CW'(1);
                end
            end
            S_FETCH: begin
                if (fe_rd) fail_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    mem_we    = 1'b1;
                    mem_waddr = fcnt_q;
                    mem_wdata = in_data;
                    in_req_d  = 1'b0;
                    fcnt_d    = fcnt_q + AW'(1);
                    if (fcnt_q == AW'(PAGE_WORDS - 1)) begin
                        // Word 0 landed on an earlier beat, so it can be presented now.
                        state_d    = S_SERVE;
                        rptr_d     = '0;
                        fe_rdata_d = mem[0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        fe_busy_d      = (state_d == S_DRAIN) || (state_d == S_FETCH);
        in_ready_d     = (state_d == S_FETCH);
        fe_status_d    = '0;
        fe_status_d[6] = ~fe_busy_d;
        fe_status_d[5] = ~fe_busy_d;
        fe_status_d[0] = fail_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            wcnt_q      <= '0;
            dptr_q      <= '0;
            fcnt_q      <= '0;
            rptr_q      <= '0;
            fail_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            fe_rdata_q  <= '0;
            fe_busy_q   <= 1'b0;
            fe_status_q <= DATA_W'(16'h0060);
            in_req_q    <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            wcnt_q      <= wcnt_d;
            dptr_q      <= dptr_d;
            fcnt_q      <= fcnt_d;
            rptr_q      <= rptr_d;
            fail_q      <= fail_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            fe_rdata_q  <= fe_rdata_d;
            fe_busy_q   <= fe_busy_d;
            fe_status_q <= fe_status_d;
            in_req_q    <= in_req_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign fe_rdata  = fe_rdata_q;
    assign fe_busy   = fe_busy_q;
    assign fe_status = fe_status_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_row   = row_q;
    assign in_req    = in_req_q;
    assign in_row    = row_q;
    assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_fsmc_page_buffer.sv
// -----------------------------------------------------------------------------
// tb_fsmc_page_buffer
//   Randomized bench for fsmc_page_buffer. Program pages push their expected
//   drain beats into a scoreboard queue; an independent monitor pops and
//   compares on every out_valid&out_ready. Reads are checked against a page
//   array kept by the bench.
// -----------------------------------------------------------------------------
module tb_fsmc_page_buffer;
    localparam int DW = 16;
    localparam int PW = 16;
    localparam int RW = 16;
`ifdef FSMC_PAGE_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fe_prog_start = 1'b0, fe_prog_commit = 1'b0, fe_read_start = 1'b0;
    logic [RW-1:0] fe_row = '0;
    logic          fe_wr = 1'b0, fe_rd = 1'b0;
    logic [DW-1:0] fe_wdata = '0;
    logic [DW-1:0] fe_rdata, fe_status, out_data, in_data = '0;
    logic          fe_busy, out_valid, out_last, in_req, in_ready;
    logic          out_ready = 1'b1, in_valid = 1'b0;
    logic [RW-1:0] out_row, in_row;

    fsmc_page_buffer #(.DATA_W(DW), .PAGE_WORDS(PW), .ROW_W(RW)) dut (
        .clk(clk), .reset(reset),
        .fe_prog_start(fe_prog_start), .fe_prog_commit(fe_prog_commit),
        .fe_read_start(fe_read_start), .fe_row(fe_row),
        .fe_wr(fe_wr), .fe_wdata(fe_wdata), .fe_rd(fe_rd), .fe_rdata(fe_rdata),
        .fe_busy(fe_busy), .fe_status(fe_status),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_row(out_row),
        .in_req(in_req), .in_row(in_row), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
        logic [RW-1:0] row;
    } beat_t;
    beat_t sb[$];

    // out_ready pattern: 0 = held high, 1 = toggling, 2 = random
    int rmode = 0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard monitor
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, prev_data);
            end
            if (out_valid) chk("busy_while_draining", fe_busy, 1'b1);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got data %h with nothing expected", out_data);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_last", out_last, e.last);
                    chk("out_row", out_row, e.row);
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic exp_fail = 1'b0;

    function automatic logic [31:0] exp_status(input logic f);
        return f ? 32'h0061 : 32'h0060;
    endfunction

    // Program k words to row; seq selects data 0..k-1 instead of random.
    task automatic prog(input logic [RW-1:0] row, input int k, input int mode,
                        input bit seq, input bit nowait);
        logic [DW-1:0] w[$];
        int n, t;
        beat_t b;
        rmode = mode;
        fe_row = row;
        fe_prog_start = 1'b1;
        cyc();
        fe_prog_start = 1'b0;
        exp_fail = 1'b0;
        for (int i = 0; i < k; i++) begin
            fe_wr    = 1'b1;
            fe_wdata = seq ? DW'(i) : DW'($urandom);
            w.push_back(fe_wdata);
            cyc();
            fe_wr = 1'b0;
            if ($urandom_range(0, 1) == 1) cyc();
        end
        if (k > PW) exp_fail = 1'b1;
        n = PAD ? PW : ((k < PW) ? k : PW);
        if (n == 0) exp_fail = 1'b1;
        for (int i = 0; i < n; i++) begin
            b.d    = (i < k) ? w[i] : 16'hFFFF;
            b.last = (i == n - 1);
            b.row  = row;
            sb.push_back(b);
        end
        fe_prog_commit = 1'b1;
        cyc();
        fe_prog_commit = 1'b0;
        chk("busy_after_commit", fe_busy, (n > 0) ? 1'b1 : 1'b0);
        if (!nowait) begin
            t = 0;
            while ((sb.size() != 0 || fe_busy) && t < 400) begin
                cyc();
                t++;
            end
            if (t >= 400) begin
                total++;
                bad++;
                $display("FAIL drain_timeout: %0d beats still expected", sb.size());
            end
            if (mode == 0 && n > 0) chk("drain_cycles", t, n + 1);
            chk("status_after_drain", fe_status, exp_status(exp_fail));
        end
    endtask

    // Fetch a page of 16'hA000+i from fabric, then read it back (plus one extra).
    task automatic fetch_read(input logic [RW-1:0] row);
        int i, t;
        logic hs;
        logic [DW-1:0] page[PW];
        fe_row = row;
        fe_read_start = 1'b1;
        cyc();
        fe_read_start = 1'b0;
        exp_fail = 1'b0;
        chk("fetch_in_req", in_req, 1'b1);
        chk("fetch_in_row", in_row, row);
        chk("fetch_busy", fe_busy, 1'b1);
        chk("fetch_in_ready", in_ready, 1'b1);
        for (int j = 0; j < PW; j++) page[j] = 16'hA000 + DW'(j);
        i = 0;
        t = 0;
        while (i < PW && t < 500) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = page[i];
            @(negedge clk);
            hs = in_valid && in_ready;
            cyc();
            if (hs) i++;
            t++;
        end
        in_valid = 1'b0;
        if (t >= 500) begin
            total++;
            bad++;
            $display("FAIL fetch_timeout: only %0d beats taken", i);
        end
        chk("busy_after_fetch", fe_busy, 1'b0);
        chk("in_req_after_fetch", in_req, 1'b0);
        chk("in_ready_after_fetch", in_ready, 1'b0);
        for (int j = 0; j <= PW; j++) begin
            chk("rdata", fe_rdata, (j < PW) ? {16'h0, page[j]} : 32'hFFFF);
            if (j == PW) chk("status_before_overread", fe_status, exp_status(exp_fail));
            fe_rd = 1'b1;
            cyc();
            fe_rd = 1'b0;
            cyc();
        end
        exp_fail = 1'b1;
        chk("status_after_overread", fe_status, exp_status(exp_fail));
    endtask

    initial begin
        repeat (2) cyc();
        #1;
        chk("rst_busy", fe_busy, 1'b0);
        chk("rst_status", fe_status, 32'h0060);
        chk("rst_rdata", fe_rdata, 0);
        chk("rst_out", {out_valid, out_last, out_data, out_row}, 0);
        chk("rst_in", {in_req, in_ready, in_row}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc();

        // Full page of 0..15, ready held high
        prog(16'h0000, 16, 0, 1'b1, 1'b0);
        // Short page
        prog(16'h0042, 3, 0, 1'b0, 1'b0);
        // Overfill: 17th word dropped and fail set
        prog(16'h0007, 17, 2, 1'b0, 1'b0);
        fe_row = 16'h0001;
        fe_prog_start = 1'b1;
        cyc();
        fe_prog_start = 1'b0;
        chk("status_cleared_by_start", fe_status, 32'h0060);
        // Toggling ready
        prog(16'h1234, 16, 1, 1'b0, 1'b0);
        prog(16'h0555, 5, 1, 1'b0, 1'b0);
        // Fetch row 5 and read it back
        fetch_read(16'h0005);
        // Random mix, including empty commits
        prog(16'h0009, 0, 0, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++)
            prog(RW'($urandom), $urandom_range(0, 18), $urandom_range(0, 2), 1'b0, 1'b0);

        // Reset in the middle of a drain
        prog(16'h00AA, 16, 0, 1'b0, 1'b1);
        repeat (4) cyc();
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_busy", fe_busy, 1'b0);
        chk("midrst_status", fe_status, 32'h0060);
        chk("midrst_out", {out_valid, out_last, out_data, out_row}, 0);
        chk("midrst_in", {in_req, in_ready, in_row}, 0);
        chk("midrst_rdata", fe_rdata, 0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc();
        prog(16'h0077, 16, 2, 1'b0, 1'b0);

        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a hung handshake
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
